lcd_page_sched: RTL

//  Shares the single character-LCD path (string formatter + displcd) among NREQ content

---
 rtl/lcd_page_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_page_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_page_sched
//  Purpose  : Shares one character-LCD path among NREQ content pages.
//             Picks the page routed to the formatter (sel), holds it stable
//             for SETTLE cycles, fires a one-cycle refresh/ack, then
//             blocks further refreshes for HOLD_CYCLES so that an LCD write
//             in progress always completes.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_page_sched #(
    parameter int NREQ        = 4,
    parameter int SELW        = 2,
    parameter int SETTLE      = 2,
    parameter int HOLD_CYCLES = 2000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            lock,
    input  logic            step,
    output logic [SELW-1:0] sel,
    output logic            refresh,
    output logic [NREQ-1:0] ack,
    output logic            busy,
    output logic [SELW-1:0] lock_pg
);

    localparam int c_CNT_MAX = (SETTLE > HOLD_CYCLES) ? SETTLE : HOLD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIRE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [SELW-1:0]      r_sel, w_sel_nxt;
    logic [SELW-1:0]      r_last, w_last_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]      r_pending, w_pending_nxt;
    logic [SELW-1:0]      r_lock_pg, w_lock_pg_nxt;
    logic                 r_lock_d;
    logic                 r_refresh, w_fire_nxt;
    logic [NREQ-1:0]      r_ack, w_ack_nxt;
    logic [NREQ-1:0]      w_set, w_clr, w_lock_mask, w_elig;
    logic [SELW-1:0]      w_grant;
    logic [SELW-1:0]      w_idx_s;
    logic                 w_found;
    int                   w_idx;

    assign sel     = r_sel;
    assign refresh = r_refresh;
    assign ack     = r_ack;
    assign busy    = (r_state != ST_IDLE);
    assign lock_pg = r_lock_pg;

    // Pending set sources (req, locked-page step, lock rising edge) and eligibility mask
    always_comb begin
        w_lock_pg_nxt = r_lock_pg;
        w_set         = req;
        if (lock && step) begin
            if (r_lock_pg == SELW'(NREQ - 1)) begin
                w_lock_pg_nxt = '0;
            end else begin
                w_lock_pg_nxt = r_lock_pg + 1'b1;
            end
            w_set[w_lock_pg_nxt] = 1'b1;
        end
        if (lock && !r_lock_d) begin
            w_set[r_lock_pg] = 1'b1;
        end
        w_lock_mask            = '0;
        w_lock_mask[r_lock_pg] = 1'b1;
        // Same-cycle req is eligible so an idle scheduler reacts without an extra cycle
        w_elig = (r_pending | req) & (lock ? w_lock_mask : {NREQ{1'b1}});
        // Set wins over the FIRE clear so a re-request during FIRE is serviced again
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
    end

    // Round-robin search: first eligible page after the last grant, with wrap
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_idx   = 0;
        w_idx_s = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_idx_s = SELW'(w_idx);
            if (!w_found && w_elig[w_idx_s]) begin
                w_found = 1'b1;
                w_grant = w_idx_s;
            end
        end
    end

    // Next-state logic; sel only moves on IDLE->LOAD so the string stays stable during a write
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_fire_nxt  = 1'b0;
        w_ack_nxt   = '0;
        w_clr       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_grant;
                    w_last_nxt  = w_grant;
                    w_cnt_nxt   = c_CNT_W'(SETTLE - 1);
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (r_cnt == '0) begin
                    w_fire_nxt       = 1'b1;
                    w_ack_nxt[r_sel] = 1'b1;
                    w_state_nxt      = ST_FIRE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_FIRE: begin
                w_clr[r_sel] = 1'b1;
                w_cnt_nxt    = c_CNT_W'(HOLD_CYCLES - 1);
                w_state_nxt  = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: selection, counter, pending flags, lock page, registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_last    <= SELW'(NREQ - 1);
            r_cnt     <= '0;
            r_pending <= '0;
            r_lock_pg <= '0;
            r_lock_d  <= 1'b0;
            r_refresh <= 1'b0;
            r_ack     <= '0;
        end else begin
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_lock_pg <= w_lock_pg_nxt;
            r_lock_d  <= lock;
            r_refresh <= w_fire_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

endmodule
`default_nettype wire
